// File: rtl/ex_issue_stage.sv
// ex_issue_stage: ID/EX pipeline register with ALU-control encoding.
// Decodes opcode/funct into a 3-bit ALU code, selects and extends the
// operands, and registers them for EX. It also handles hazard-unit
// stall (hold) and flush (bubble).
// Optional build macro: EX_FWD_EN adds EX/MEM and MEM/WB operand forwarding.
//
// Handshake: there is no ready signal. id_valid qualifies the ID fields in
// the cycle they are presented. ex_valid qualifies the EX outputs one cycle
// later. stall freezes the EX register, and flush overrides stall.
module ex_issue_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic [4:0]      shamt,
  input  logic [15:0]     imm16,
  input  logic [RW-1:0]   rs,
  input  logic [RW-1:0]   rt,
  input  logic [RW-1:0]   rd,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
`ifdef EX_FWD_EN
  input  logic            exmem_regwrite,
  input  logic [RW-1:0]   exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_regwrite,
  input  logic [RW-1:0]   memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
`endif
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_c,
  output logic [RW-1:0]   ex_dest,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_illegal
);

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SUBZ = 3'b110;
  localparam logic [2:0] ALU_SUBN = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLL = 6'b000000;

  logic [XLEN-1:0] imm_se;
  logic [XLEN-1:0] shamt_ze;
  logic            d_ok;
  logic [2:0]      d_c;
  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic [RW-1:0]   d_dest;
  logic            d_rw;
  logic            d_mr;
  logic            d_mw;
  logic            d_br;

  // Registered operand values before any forwarding.
  logic [XLEN-1:0] q_a;
  logic [XLEN-1:0] q_b;
  logic [XLEN-1:0] q_sd;

  assign imm_se   = {{(XLEN-16){imm16[15]}}, imm16};
  assign shamt_ze = {{(XLEN-5){1'b0}}, shamt};

  // Decode the ID fields into the ALU code, operands, destination and flags.
  // Instructions that do not write back (sw, branches) carry destination 0.
  always_comb begin
    d_ok   = 1'b0;
    d_c    = ALU_AND;
    d_a    = '0;
    d_b    = '0;
    d_dest = '0;
    d_rw   = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_br   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_dest = rd;
        d_rw   = 1'b1;
        d_a    = rs_data;
        d_b    = rt_data;
        case (funct)
          F_AND: begin d_ok = 1'b1; d_c = ALU_AND; end
          F_OR:  begin d_ok = 1'b1; d_c = ALU_OR;  end
          F_ADD: begin d_ok = 1'b1; d_c = ALU_ADD; end
          F_SUB: begin d_ok = 1'b1; d_c = ALU_SUBZ; end
          F_SLL: begin
            d_ok = 1'b1;
            d_c  = ALU_SLL;
            d_a  = rt_data;
            d_b  = shamt_ze;
          end
          default: d_ok = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d_ok = 1'b1; d_c = ALU_ADD; d_a = rs_data; d_b = imm_se;
        d_dest = rt; d_rw = 1'b1;
      end
      OP_LW: begin
        d_ok = 1'b1; d_c = ALU_ADD; d_a = rs_data; d_b = imm_se;
        d_dest = rt; d_rw = 1'b1; d_mr = 1'b1;
      end
      OP_SW: begin
        d_ok = 1'b1; d_c = ALU_ADD; d_a = rs_data; d_b = imm_se;
        d_mw = 1'b1;
      end
      OP_BEQ: begin
        d_ok = 1'b1; d_c = ALU_SUBZ; d_a = rs_data; d_b = rt_data;
        d_br = 1'b1;
      end
      OP_BNE: begin
        d_ok = 1'b1; d_c = ALU_SUBN; d_a = rs_data; d_b = rt_data;
        d_br = 1'b1;
      end
      default: d_ok = 1'b0;
    endcase
    // Writes to register 0 are discarded.
    if (d_dest == '0) d_rw = 1'b0;
  end

  // EX register: reset > flush > stall > load instruction / load bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid    <= 1'b0;
      q_a         <= '0;
      q_b         <= '0;
      alu_c       <= ALU_AND;
      ex_dest     <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      q_sd        <= '0;
      ex_illegal  <= 1'b0;
    end else if (stall) begin
      ex_valid <= ex_valid;
    end else if (id_valid && d_ok) begin
      ex_valid    <= 1'b1;
      q_a         <= d_a;
      q_b         <= d_b;
      alu_c       <= d_c;
      ex_dest     <= d_dest;
      ex_regwrite <= d_rw;
      ex_memread  <= d_mr;
      ex_memwrite <= d_mw;
      ex_branch   <= d_br;
      q_sd        <= rt_data;
      ex_illegal  <= 1'b0;
    end else begin
      ex_valid    <= 1'b0;
      q_a         <= '0;
      q_b         <= '0;
      alu_c       <= ALU_AND;
      ex_dest     <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      q_sd        <= '0;
      ex_illegal  <= id_valid;
    end
  end

`ifdef EX_FWD_EN
  // Source specifiers and forwardability of each operand, held in EX.
  logic [RW-1:0] ex_a_src;
  logic [RW-1:0] ex_rt;
  logic          ex_b_fwd;
  logic          ex_sd_fwd;
  logic          id_is_sll;
  logic          id_b_reg;

  assign id_is_sll = (opcode == OP_RTYPE) && (funct == F_SLL);
  assign id_b_reg  = ((opcode == OP_RTYPE) && !id_is_sll) ||
                     (opcode == OP_BEQ) || (opcode == OP_BNE);

  // Track the specifiers alongside the EX register with the same priority.
  // Operand a is register-sourced for every legal instruction (rt for sll).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_a_src  <= '0;
      ex_rt     <= '0;
      ex_b_fwd  <= 1'b0;
      ex_sd_fwd <= 1'b0;
    end else if (stall) begin
      ex_a_src  <= ex_a_src;
    end else if (id_valid && d_ok) begin
      ex_a_src  <= id_is_sll ? rt : rs;
      ex_rt     <= rt;
      ex_b_fwd  <= id_b_reg;
      ex_sd_fwd <= 1'b1;
    end else begin
      ex_a_src  <= '0;
      ex_rt     <= '0;
      ex_b_fwd  <= 1'b0;
      ex_sd_fwd <= 1'b0;
    end
  end

  // Pick the newest in-flight value for a specifier; EX/MEM is younger.
  function automatic logic [XLEN-1:0] fwd_pick(input logic [RW-1:0] src,
                                               input logic [XLEN-1:0] base);
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src))
      return exmem_data;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src))
      return memwb_data;
    else
      return base;
  endfunction

  assign alu_a         = ex_valid  ? fwd_pick(ex_a_src, q_a) : q_a;
  assign alu_b         = ex_b_fwd  ? fwd_pick(ex_rt, q_b)    : q_b;
  assign ex_store_data = ex_sd_fwd ? fwd_pick(ex_rt, q_sd)   : q_sd;
`else
  // rs only matters as a forwarding specifier.
  logic unused_rs;
  assign unused_rs     = ^rs;
  assign alu_a         = q_a;
  assign alu_b         = q_b;
  assign ex_store_data = q_sd;
`endif

endmodule

// File: tb/tb_ex_issue_stage.sv
// tb_ex_issue_stage: vector table plus hand sequences for stall, flush and
// reset corner cases; forwarding checks when EX_FWD_EN is defined.
module tb_ex_issue_stage;

  localparam int OW = 1 + 32 + 32 + 3 + 5 + 4 + 32 + 1;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic        stall;
  logic        flush;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ex_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_c;
  logic [4:0]  ex_dest;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_branch;
  logic [31:0] ex_store_data;
  logic        ex_illegal;
`ifdef EX_FWD_EN
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_data;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
`endif

  ex_issue_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
    .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
    .rs(rs), .rt(rt), .rd(rd), .rs_data(rs_data), .rt_data(rt_data),
`ifdef EX_FWD_EN
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
`endif
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic          iv;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic [4:0]    sh;
    logic [15:0]   imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [31:0]   rsd;
    logic [31:0]   rtd;
    logic [OW-1:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vt[NV];

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] act;
  logic [OW-1:0] zero_exp;
  int passed;
  int total;

  assign act = {ex_valid, alu_a, alu_b, alu_c, ex_dest, ex_regwrite,
                ex_memread, ex_memwrite, ex_branch, ex_store_data, ex_illegal};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pk(input logic v, input logic [31:0] a,
      input logic [31:0] b, input logic [2:0] c, input logic [4:0] d,
      input logic rw, input logic mr, input logic mw, input logic br,
      input logic [31:0] sd, input logic il);
    return {v, a, b, c, d, rw, mr, mw, br, sd, il};
  endfunction

  // Driver tasks
  task automatic drive_vec(input vec_t v);
    id_valid = v.iv; opcode = v.op; funct = v.fn; shamt = v.sh; imm16 = v.imm;
    rs = v.rs; rt = v.rt; rd = v.rd; rs_data = v.rsd; rt_data = v.rtd;
  endtask

  task automatic drive_random();
    id_valid = 1'b1;
    opcode = 6'($urandom_range(0, 63)); funct = 6'($urandom_range(0, 63));
    shamt = 5'($urandom_range(0, 31)); imm16 = 16'($urandom_range(0, 65535));
    rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
    rd = 5'($urandom_range(0, 31));
    rs_data = $urandom; rt_data = $urandom;
  endtask

  // Scoreboard: compare one expected value against the DUT outputs.
  task automatic check(input string nm, input logic [OW-1:0] got);
    logic [OW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got %h", nm, got);
      return;
    end
    e = exp_q.pop_front();
    if (got === e) passed++;
    else $display("FAIL %s: got %h want %h", nm, got, e);
  endtask

  task automatic step_check(input string nm);
    @(posedge clk);
    #1;
    check(nm, act);
  endtask

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  initial begin
    passed = 0;
    total = 0;
    zero_exp = '0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; opcode = '0; funct = '0; shamt = '0; imm16 = '0;
    rs = '0; rt = '0; rd = '0; rs_data = '0; rt_data = '0;
`ifdef EX_FWD_EN
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_data = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_data = '0;
`endif

    //          iv  op     fn     sh  imm       rs  rt  rd  rsd           rtd
    vt[0]  = '{1'b1, 6'h00, 6'h20, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
               pk(1, 32'd5, 32'd7, 3'b010, 5'd3, 1, 0, 0, 0, 32'd7, 0)};
    vt[1]  = '{1'b1, 6'h23, 6'h00, 5'd0, 16'hFFFC, 5'd1, 5'd8, 5'd0, 32'h100, 32'd9,
               pk(1, 32'h100, 32'hFFFFFFFC, 3'b010, 5'd8, 1, 1, 0, 0, 32'd9, 0)};
    vt[2]  = '{1'b1, 6'h00, 6'h00, 5'd4, 16'h0000, 5'd1, 5'd2, 5'd5, 32'hAA, 32'd1,
               pk(1, 32'd1, 32'd4, 3'b101, 5'd5, 1, 0, 0, 0, 32'd1, 0)};
    vt[3]  = '{1'b1, 6'h00, 6'h22, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd6, 32'd10, 32'd3,
               pk(1, 32'd10, 32'd3, 3'b110, 5'd6, 1, 0, 0, 0, 32'd3, 0)};
    vt[4]  = '{1'b1, 6'h00, 6'h24, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd7, 32'hF0F0, 32'hFF00,
               pk(1, 32'hF0F0, 32'hFF00, 3'b000, 5'd7, 1, 0, 0, 0, 32'hFF00, 0)};
    vt[5]  = '{1'b1, 6'h00, 6'h25, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd31, 32'h1234, 32'h8000,
               pk(1, 32'h1234, 32'h8000, 3'b001, 5'd31, 1, 0, 0, 0, 32'h8000, 0)};
    vt[6]  = '{1'b1, 6'h08, 6'h3F, 5'd3, 16'h7FFF, 5'd1, 5'd9, 5'd2, 32'd2, 32'd11,
               pk(1, 32'd2, 32'h00007FFF, 3'b010, 5'd9, 1, 0, 0, 0, 32'd11, 0)};
    vt[7]  = '{1'b1, 6'h08, 6'h00, 5'd0, 16'h0001, 5'd1, 5'd0, 5'd2, 32'd2, 32'd11,
               pk(1, 32'd2, 32'd1, 3'b010, 5'd0, 0, 0, 0, 0, 32'd11, 0)};
    vt[8]  = '{1'b1, 6'h2B, 6'h00, 5'd0, 16'h0008, 5'd1, 5'd4, 5'd0, 32'h200, 32'hDEAD,
               pk(1, 32'h200, 32'd8, 3'b010, 5'd0, 0, 0, 1, 0, 32'hDEAD, 0)};
    vt[9]  = '{1'b1, 6'h04, 6'h00, 5'd0, 16'h0010, 5'd1, 5'd4, 5'd0, 32'd3, 32'd3,
               pk(1, 32'd3, 32'd3, 3'b110, 5'd0, 0, 0, 0, 1, 32'd3, 0)};
    vt[10] = '{1'b1, 6'h05, 6'h00, 5'd0, 16'hFFF0, 5'd1, 5'd4, 5'd0, 32'd3, 32'd4,
               pk(1, 32'd3, 32'd4, 3'b111, 5'd0, 0, 0, 0, 1, 32'd4, 0)};
    vt[11] = '{1'b1, 6'h3F, 6'h20, 5'd0, 16'h1234, 5'd1, 5'd4, 5'd5, 32'd3, 32'd4,
               pk(0, 32'd0, 32'd0, 3'b000, 5'd0, 0, 0, 0, 0, 32'd0, 1)};
    vt[12] = '{1'b1, 6'h00, 6'h3F, 5'd0, 16'h0000, 5'd1, 5'd4, 5'd5, 32'd3, 32'd4,
               pk(0, 32'd0, 32'd0, 3'b000, 5'd0, 0, 0, 0, 0, 32'd0, 1)};
    vt[13] = '{1'b0, 6'h00, 6'h20, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
               pk(0, 32'd0, 32'd0, 3'b000, 5'd0, 0, 0, 0, 0, 32'd0, 0)};
    vt[14] = '{1'b1, 6'h00, 6'h20, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd0, 32'd9, 32'd1,
               pk(1, 32'd9, 32'd1, 3'b010, 5'd0, 0, 0, 0, 0, 32'd1, 0)};
    vt[15] = '{1'b1, 6'h23, 6'h00, 5'd0, 16'h8000, 5'd3, 5'd6, 5'd0, 32'h0, 32'd2,
               pk(1, 32'h0, 32'hFFFF8000, 3'b010, 5'd6, 1, 1, 0, 0, 32'd2, 0)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(zero_exp);
    check("reset", act);
    reset = 1'b0;

    // Idle after reset
    exp_q.push_back(zero_exp);
    step_check("idle");

    // Vector table
    for (int i = 0; i < NV; i++) begin
      drive_vec(vt[i]);
      exp_q.push_back(vt[i].exp);
      step_check($sformatf("vec%0d", i));
    end

    // Illegal lasts one cycle: the next valid instruction clears it.
    drive_vec(vt[11]);
    exp_q.push_back(vt[11].exp);
    step_check("illegal_set");
    drive_vec(vt[3]);
    exp_q.push_back(vt[3].exp);
    step_check("illegal_clear");

    // Stall for 3 cycles with changing ID inputs: outputs frozen.
    drive_vec(vt[0]);
    exp_q.push_back(vt[0].exp);
    step_check("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      exp_q.push_back(vt[0].exp);
      step_check($sformatf("stall%0d", i));
    end

    // Flush and stall together: flush wins.
    flush = 1'b1;
    exp_q.push_back(zero_exp);
    step_check("flush_stall");
    flush = 1'b0;
    stall = 1'b0;

    // Flush alone over a valid instruction and over a held illegal flag.
    drive_vec(vt[12]);
    exp_q.push_back(vt[12].exp);
    step_check("illegal_pre_flush");
    drive_vec(vt[1]);
    flush = 1'b1;
    exp_q.push_back(zero_exp);
    step_check("flush");
    flush = 1'b0;

    // Stall holds the illegal flag too.
    drive_vec(vt[11]);
    exp_q.push_back(vt[11].exp);
    step_check("illegal_pre_stall");
    stall = 1'b1;
    drive_vec(vt[2]);
    exp_q.push_back(vt[11].exp);
    step_check("illegal_stalled");
    stall = 1'b0;

    // Reset asserted mid-stall.
    drive_vec(vt[2]);
    exp_q.push_back(vt[2].exp);
    step_check("pre_reset_stall");
    stall = 1'b1;
    drive_random();
    exp_q.push_back(vt[2].exp);
    step_check("stall_before_reset");
    reset = 1'b1;
    exp_q.push_back(zero_exp);
    step_check("reset_mid_stall");
    reset = 1'b0;
    stall = 1'b0;

`ifdef EX_FWD_EN
    // Both EX/MEM and MEM/WB write r4: EX/MEM wins.
    drive_vec('{1'b1, 6'h00, 6'h22, 5'd0, 16'h0, 5'd4, 5'd5, 5'd7, 32'd1, 32'd2, zero_exp});
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_data = 32'h55;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_data = 32'h66;
    @(posedge clk);
    #1;
    check32("fwd_exmem_a", alu_a, 32'h55);
    check32("fwd_none_b", alu_b, 32'd2);
    exmem_regwrite = 1'b0;
    #1;
    check32("fwd_memwb_a", alu_a, 32'h66);
    memwb_rd = 5'd5;
    #1;
    check32("fwd_memwb_b", alu_b, 32'h66);
    check32("fwd_memwb_sd", ex_store_data, 32'h66);

    // Register 0 is never forwarded.
    drive_vec('{1'b1, 6'h00, 6'h22, 5'd0, 16'h0, 5'd0, 5'd5, 5'd7, 32'd1, 32'd2, zero_exp});
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_data = 32'h55;
    memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_data = 32'h66;
    @(posedge clk);
    #1;
    check32("fwd_r0_a", alu_a, 32'd1);

    // Immediate operand is never forwarded.
    drive_vec('{1'b1, 6'h08, 6'h00, 5'd0, 16'h0003, 5'd4, 5'd4, 5'd0, 32'd1, 32'd2, zero_exp});
    exmem_rd = 5'd4;
    @(posedge clk);
    #1;
    check32("fwd_imm_a", alu_a, 32'h55);
    check32("fwd_imm_b", alu_b, 32'd3);
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
`endif

    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
